// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 color receiver: drain FSM states, per-segment pixel bits,
// and the column-index width helper.
package hub75_pkg;

  typedef enum logic {
    IDLE,
    DRAIN
  } rx_state_t;

  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } px_bit_t;

  function automatic int unsigned col_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_rx_edge_det.sv
// Optional two-flop synchronizer (HUB75_RX_SYNC_EN) followed by a registered rise detector.
// Provides both the (synchronized) level and a one-cycle rise strobe.
module hub75_rx_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise
);

  logic w_sig;
  logic r_prev;

`ifdef HUB75_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_sig};
  end

  assign w_sig = r_sync[1];
`else
  assign w_sig = i_sig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_sig;
  end

  assign o_level = w_sig;
  assign o_rise  = w_sig & ~r_prev;

endmodule

// File: rtl/hub75_color_rx.sv
// HUB75 serial color bus receiver: captures one bit-plane row per latch and streams it out
// one column per valid/ready beat. Define HUB75_RX_SYNC_EN to synchronize all panel inputs.
module hub75_color_rx
  import hub75_pkg::*;
#(
  parameter  int unsigned hpixel_p   = 64,
  parameter  int unsigned segments_p = 2,
  localparam int unsigned COL_W      = col_width(hpixel_p)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_serial_clk,
  input  logic [segments_p-1:0] i_red,
  input  logic [segments_p-1:0] i_green,
  input  logic [segments_p-1:0] i_blue,
  input  logic                  i_latch_en,
  output logic                  o_px_valid,
  input  logic                  i_px_ready,
  output logic [COL_W-1:0]      o_px_col,
  output logic [segments_p-1:0] o_px_red,
  output logic [segments_p-1:0] o_px_green,
  output logic [segments_p-1:0] o_px_blue,
  output logic                  o_row_done,
  output logic                  o_len_err,
  output logic                  o_ovf_err
);

  localparam int unsigned      CNT_W = $clog2(hpixel_p + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(hpixel_p);
  localparam logic [COL_W-1:0] LAST  = COL_W'(hpixel_p - 1);

  logic w_sclk_lvl, w_sclk_rise;
  logic w_latch_lvl, w_latch_rise;

  hub75_rx_edge_det u_sclk_det (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (i_serial_clk),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise)
  );

  hub75_rx_edge_det u_latch_det (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (i_latch_en),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise)
  );

  logic [3*segments_p-1:0] w_lanes;

`ifdef HUB75_RX_SYNC_EN
  logic [3*segments_p-1:0] r_lane_s1, r_lane_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_s1 <= '0;
      r_lane_s2 <= '0;
    end else begin
      r_lane_s1 <= {i_red, i_green, i_blue};
      r_lane_s2 <= r_lane_s1;
    end
  end

  assign w_lanes = r_lane_s2;
`else
  assign w_lanes = {i_red, i_green, i_blue};
`endif

  px_bit_t [segments_p-1:0] w_col_in;

  always_comb begin
    w_col_in = '0;
    for (int unsigned s = 0; s < segments_p; s++) begin
      w_col_in[s].red   = w_lanes[2*segments_p + s];
      w_col_in[s].green = w_lanes[segments_p + s];
      w_col_in[s].blue  = w_lanes[s];
    end
  end

  // Capture side
  px_bit_t [segments_p-1:0] r_cap [hpixel_p];
  px_bit_t [segments_p-1:0] r_buf [hpixel_p];
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_shift;

  // A latch rise always has the latch level high, so a coincident sclk rise is dropped here too.
  assign w_shift = w_sclk_rise & w_sclk_lvl & ~w_latch_lvl & (r_cnt != FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < hpixel_p; i++) r_cap[i] <= '0;
      r_cnt <= '0;
    end else if (w_latch_rise) begin
      for (int unsigned i = 0; i < hpixel_p; i++) r_cap[i] <= '0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cap[r_cnt[COL_W-1:0]] <= w_col_in;
      r_cnt                   <= r_cnt + 1'b1;
    end
  end

  // Drain FSM
  rx_state_t        r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             w_accept, w_accept_last, w_free, w_load;
  logic             r_row_done, r_len_err, r_ovf_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    o_px_valid    = 1'b0;
    w_accept      = 1'b0;
    w_accept_last = 1'b0;
    case (r_state)
      IDLE: ;
      DRAIN: begin
        o_px_valid    = 1'b1;
        w_accept      = i_px_ready;
        w_accept_last = i_px_ready && (r_col == LAST);
        if (w_accept) w_col_nxt = r_col + 1'b1;
        if (w_accept_last) begin
          w_state_nxt = IDLE;
          w_col_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // The buffer is free again in the cycle its last beat is accepted.
    w_free = (r_state == IDLE) || w_accept_last;
    w_load = w_latch_rise && w_free;
    if (w_load) begin
      w_state_nxt = DRAIN;
      w_col_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row_done <= 1'b0;
      r_len_err  <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row_done <= w_accept_last;
      r_len_err  <= w_latch_rise && (r_cnt != FULL);
      r_ovf_err  <= w_latch_rise && !w_free;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < hpixel_p; i++) r_buf[i] <= '0;
    end else if (w_load) begin
      r_buf <= r_cap;
    end
  end

  always_comb begin
    o_px_red   = '0;
    o_px_green = '0;
    o_px_blue  = '0;
    for (int unsigned s = 0; s < segments_p; s++) begin
      o_px_red[s]   = r_buf[r_col][s].red;
      o_px_green[s] = r_buf[r_col][s].green;
      o_px_blue[s]  = r_buf[r_col][s].blue;
    end
  end

  assign o_px_col   = r_col;
  assign o_row_done = r_row_done;
  assign o_len_err  = r_len_err;
  assign o_ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_hub75_color_rx.sv
// Directed bench for hub75_color_rx: loopback, short row, backpressure, overflow,
// latch-on-last-beat boundary and reset mid-drain. Honors HUB75_RX_SYNC_EN for latencies.
`timescale 1ns/1ps
module tb_hub75_color_rx;

  localparam int unsigned HP  = 64;
  localparam int unsigned SEG = 2;
`ifdef HUB75_RX_SYNC_EN
  localparam int LAT = 3;
  localparam int DIV = 8;
`else
  localparam int LAT = 1;
  localparam int DIV = 4;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sclk = 1'b0;
  logic           latch = 1'b0;
  logic           ready = 1'b0;
  logic [SEG-1:0] red = '0, green = '0, blue = '0;
  logic           valid, row_done, len_err, ovf_err;
  logic [5:0]     col;
  logic [SEG-1:0] ored, ogreen, oblue;

  int checks = 0;
  int failures = 0;
  int n_done = 0, n_len = 0, n_ovf = 0;
  int s_done, s_len, s_ovf;

  always #5 clk = ~clk;

  hub75_color_rx #(.hpixel_p(HP), .segments_p(SEG)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_serial_clk (sclk),
    .i_red        (red),
    .i_green      (green),
    .i_blue       (blue),
    .i_latch_en   (latch),
    .o_px_valid   (valid),
    .i_px_ready   (ready),
    .o_px_col     (col),
    .o_px_red     (ored),
    .o_px_green   (ogreen),
    .o_px_blue    (oblue),
    .o_row_done   (row_done),
    .o_len_err    (len_err),
    .o_ovf_err    (ovf_err)
  );

  // Pulse counters; sampled on the rising edge, so they see the previous cycle's outputs.
  always @(posedge clk) begin
    if (row_done) n_done <= n_done + 1;
    if (len_err)  n_len  <= n_len + 1;
    if (ovf_err)  n_ovf  <= n_ovf + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Column k of pattern 0 carries k[5:0] as {r1,r0,g1,g0,b1,b0}; pattern 1 is its inverse.
  function automatic logic [5:0] pat_px(input int pat, input int k, input int nwr);
    logic [5:0] v;
    v = 6'(k);
    if (k >= nwr) return 6'h00;
    return (pat == 1) ? ~v : v;
  endfunction

  task automatic shift_row(input int pat, input int n);
    for (int k = 0; k < n; k++) begin
      {red, green, blue} = pat_px(pat, k, n);
      sclk = 1'b0;
      repeat (DIV/2) tick();
      sclk = 1'b1;
      repeat (DIV/2) tick();
    end
    sclk = 1'b0;
    {red, green, blue} = '0;
    repeat (DIV/2) tick();
  endtask

  task automatic do_latch(input logic exp_len, input logic exp_ovf);
    latch = 1'b1;
    repeat (LAT-1) tick();
    chk("valid_before_latch", valid, exp_ovf);
    tick();
    chk("valid_after_latch", valid, 1'b1);
    chk("len_err_pulse", len_err, exp_len);
    chk("ovf_err_pulse", ovf_err, exp_ovf);
    latch = 1'b0;
  endtask

  task automatic drain(input int pat, input int nwr, input bit toggle,
                       input int latch_at, input int exp_cycles);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < HP && cyc < 400) begin
      ready = toggle ? cyc[0] : 1'b1;
      if (latch_at >= 0 && k == latch_at) latch = 1'b1;
      chk("beat_valid", valid, 1'b1);
      chk("beat_col", col, k);
      chk("beat_data", {ored, ogreen, oblue}, pat_px(pat, k, nwr));
      if (ready) k++;
      tick();
      cyc++;
    end
    chk("drain_cycles", cyc, exp_cycles);
    chk("row_done_pulse", row_done, 1'b1);
  endtask

  task automatic snap();
    s_done = n_done;
    s_len  = n_len;
    s_ovf  = n_ovf;
  endtask

  task automatic deltas(input int d_done, input int d_len, input int d_ovf);
    chk("row_done_count", n_done - s_done, d_done);
    chk("len_err_count", n_len - s_len, d_len);
    chk("ovf_err_count", n_ovf - s_ovf, d_ovf);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", valid, 1'b0);
    chk("rst_col", col, 6'd0);
    chk("rst_data", {ored, ogreen, oblue}, 6'h00);
    chk("rst_row_done", row_done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_ovf_err", ovf_err, 1'b0);
    rst = 1'b0;
    tick();

    // Loopback, ready held high
    snap();
    ready = 1'b1;
    shift_row(0, HP);
    do_latch(1'b0, 1'b0);
    drain(0, HP, 1'b0, -1, HP);
    chk("loop_idle_after", valid, 1'b0);
    tick();
    chk("loop_done_one_cycle", row_done, 1'b0);
    deltas(1, 0, 0);

    // Short row: 40 columns, remainder reads zero
    snap();
    shift_row(1, 40);
    do_latch(1'b1, 1'b0);
    drain(1, 40, 1'b0, -1, HP);
    tick();
    deltas(1, 1, 0);

    // Backpressure: ready alternates 0/1
    snap();
    shift_row(0, HP);
    do_latch(1'b0, 1'b0);
    drain(0, HP, 1'b1, -1, 2*HP);
    tick();
    deltas(1, 0, 0);

    // Overflow: second latch while first row is stalled
    snap();
    ready = 1'b0;
    shift_row(0, HP);
    do_latch(1'b0, 1'b0);
    shift_row(1, HP);
    do_latch(1'b0, 1'b1);
    drain(0, HP, 1'b0, -1, HP);
    chk("ovf_second_row_absent", valid, 1'b0);
    repeat (3) tick();
    chk("ovf_still_idle", valid, 1'b0);
    deltas(1, 0, 1);

    // Boundary: latch rise on the final handshake edge
    snap();
    ready = 1'b0;
    shift_row(0, HP);
    do_latch(1'b0, 1'b0);
    shift_row(1, HP);
    drain(0, HP, 1'b0, HP - LAT, HP);
    latch = 1'b0;
    chk("bnd_valid", valid, 1'b1);
    chk("bnd_col", col, 6'd0);
    chk("bnd_data", {ored, ogreen, oblue}, 6'h3f);
    chk("bnd_no_ovf", ovf_err, 1'b0);
    chk("bnd_no_len", len_err, 1'b0);
    drain(1, HP, 1'b0, -1, HP);
    chk("bnd_idle_after", valid, 1'b0);
    tick();
    deltas(2, 0, 0);

    // Reset mid-drain
    snap();
    ready = 1'b1;
    shift_row(0, HP);
    do_latch(1'b0, 1'b0);
    repeat (20) tick();
    chk("mid_col20", col, 6'd20);
    chk("mid_data20", {ored, ogreen, oblue}, 6'd20);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_col", col, 6'd0);
    chk("mid_rst_data", {ored, ogreen, oblue}, 6'h00);
    tick();
    rst = 1'b0;
    tick();
    shift_row(1, HP);
    do_latch(1'b0, 1'b0);
    drain(1, HP, 1'b0, -1, HP);
    chk("mid_idle_after", valid, 1'b0);
    tick();
    deltas(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hub75_color_rx.md
# hub75_color_rx

Receiver for the HUB75 serial color bus. It samples the serial clock, per-segment RGB data and latch-enable lines, and reassembles one bit-plane row per latch. Captured rows are streamed out one column per beat over a valid/ready interface. It sits opposite the color transmitter, both as a loopback checker in the driver subsystem and as the front end of a panel model for system benches.

## Interface
Parameters:
- hpixel_p, 64, columns per row (shift length per latch)
- segments_p, 2, number of display segments (parallel RGB lanes)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_serial_clk  in  1  HUB75 shift clock
- i_red  in  segments_p  red data, one bit per segment
- i_green  in  segments_p  green data, one bit per segment
- i_blue  in  segments_p  blue data, one bit per segment
- i_latch_en  in  1  row latch strobe
- o_px_valid  out  1  column beat valid
- i_px_ready  in  1  column beat accepted
- o_px_col  out  $clog2(hpixel_p)  column index of current beat
- o_px_red / o_px_green / o_px_blue  out  segments_p  captured bits for o_px_col
- o_row_done  out  1  one-cycle pulse after the last column is accepted
- o_len_err  out  1  one-cycle pulse: the latched row had a shift count ≠ hpixel_p
- o_ovf_err  out  1  one-cycle pulse: latch arrived while the drain buffer was busy; row dropped

## Operation
- **Edge detection:** registered copies of the sclk and latch lines; rise = current & !previous.
- **Capture:**
  - On each sclk rise while i_latch_en is low, write the {r,g,b} lanes into capture[cnt], then cnt++.
  - cnt saturates at hpixel_p; further rises are discarded.
  - Sclk rises while the latch is high are ignored.
- **Latch rise:**
  - If cnt ≠ hpixel_p, pulse o_len_err. The row is still transferred; unwritten columns read 0.
  - If the drain FSM is IDLE, copy capture into the drain buffer and go to DRAIN.
  - Otherwise, pulse o_ovf_err and drop the row.
  - In both cases, clear capture to 0 and cnt to 0.
- **Drain FSM states:**
  - IDLE: o_px_valid = 0.
  - DRAIN: o_px_valid = 1, col starts at 0. On valid & ready, col++. On acceptance at col = hpixel_p−1, pulse o_row_done and go to IDLE.
- **Stability:** o_px_col and the data outputs hold while valid & !ready.
- **Simultaneous events:**
  - Latch rise in the same cycle the last beat is accepted: the drain buffer counts as free, the new row loads, no o_ovf_err. DRAIN restarts at col 0 with no idle cycle, and o_row_done still pulses.
  - Sclk rise in the same cycle as a latch rise: ignored.
- **Reset (asserted at any time):**
  - cnt, capture, drain buffer and edge registers cleared.
  - FSM to IDLE.
  - All outputs 0.
  - Any in-flight row is lost and no error is flagged.

## Timing
- Capture latency: an input rise sampled at clock edge N is written at edge N (data taken in the same cycle as detection). Data must be stable in the cycle sclk is first seen high.
- Latch rise detected at edge N: o_px_valid = 1 from edge N+1. Error pulses are also high in cycle N+1.
- Throughput: one column per cycle when ready is held high, so a full row drains in hpixel_p cycles.
- o_row_done is high in the cycle after the final handshake edge.
- Minimum sclk high and low time is 1 clk with no sync stages, and 2 clk with sync stages.

## Configuration
- HUB75_RX_SYNC_EN:
  - Defined: two-flop synchronizers on i_serial_clk, i_latch_en and all data lanes. All input-referenced latencies grow by 2 cycles; suitable for asynchronous panel-side pins.
  - Undefined: inputs are used directly, for same-clock loopback with the transmitter.

## Structure
- hub75_pkg holds:
  - the rx_state_t enum {IDLE, DRAIN}
  - a pixel-bit struct {red, green, blue} per segment
  - the column-width helper constant
- One sub-module, hub75_rx_edge_det: optional synchronizer plus registered rise detector. It is instantiated for sclk and latch; the data lanes use the synchronizer only.

## Test plan
- **Loopback:** transmitter with hpixel_p = 64, segments_p = 2, clk_div 4, pattern col[k] = k parity per lane, ready always 1 → 64 beats with matching bits, o_px_col 0..63, one o_row_done, no errors.
- **Short row:** 40 sclk pulses then latch → o_len_err pulse, beats 0..39 match, beats 40..63 are 0.
- **Backpressure:**
  - Ready toggled 1/0 each cycle → 128 cycles to drain, with outputs stable while stalled.
  - A second latch arriving mid-drain → o_ovf_err, second row absent.
- **Boundary:** second latch rise in the same cycle as the final handshake → no o_ovf_err, next valid beat is col 0 of the new row.
- **Reset mid-drain:** assert rst at col 20 → o_px_valid = 0 immediately. After release, a full row is received correctly starting at col 0.
- **Sync macro:** with HUB75_RX_SYNC_EN defined, rerun the loopback case at clk_div 8 → identical data, first valid 2 cycles later.
